// File: rtl/mux_col_pkg.sv
// Shared types and the round-robin pick used by the column scheduler.
package mux_col_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // First set bit of valid, searching upward from last+1 with wrap; the
    // just-served index is therefore examined last.
    function automatic logic [SEL_W-1:0] rr_next(input logic [NUM_REQ-1:0] valid,
                                                 input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_next = last;
        found   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && valid[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux_col.sv
// Four-way column data mux driven by the scheduler's grant index.
module mux_col
    import mux_col_pkg::*;
#(
    parameter int COL = 3
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic [COL-1:0]   data0_i,
    input  logic [COL-1:0]   data1_i,
    input  logic [COL-1:0]   data2_i,
    input  logic [COL-1:0]   data3_i,
    output logic [COL-1:0]   data_o
);

    always_comb begin
        data_o = data0_i;
        case (sel_i)
            2'd0:    data_o = data0_i;
            2'd1:    data_o = data1_i;
            2'd2:    data_o = data2_i;
            default: data_o = data3_i;
        endcase
    end

endmodule

// File: rtl/mux_col_rr_sched.sv
// Round-robin burst scheduler sharing one column datapath between four
// requesters, with a single registered valid/ready output stage.
module mux_col_rr_sched
    import mux_col_pkg::*;
#(
    parameter int COL   = 3,
    parameter int BURST = 4,
    parameter int CNT_W = $clog2(BURST + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [COL-1:0]     i_data1,
    input  logic [COL-1:0]     i_data2,
    input  logic [COL-1:0]     i_data3,
    input  logic [COL-1:0]     i_data4,
    output logic [NUM_REQ-1:0] o_ready,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [COL-1:0]     o_data,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_busy
);

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             vld_q, vld_d;
    logic [COL-1:0]   data_q, data_d;
    logic [COL-1:0]   mux_data;
    logic             grant_rdy;
    logic             accept;

    mux_col #(.COL(COL)) u_mux (
        .sel_i   (sel_q),
        .data0_i (i_data1),
        .data1_i (i_data2),
        .data2_i (i_data3),
        .data3_i (i_data4),
        .data_o  (mux_data)
    );

    // The granted requester may push whenever the output stage is empty or draining.
    assign grant_rdy = (state_q == GRANT) && (!vld_q || i_ready);
    assign accept    = grant_rdy && i_valid[sel_q];
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        o_ready        = '0;
        o_ready[sel_q] = grant_rdy;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        data_d  = data_q;

        if (accept) begin
            data_d = mux_data;
            vld_d  = 1'b1;
        end else if (vld_q && i_ready) begin
            vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|i_valid) begin
                    sel_d   = rr_next(i_valid, last_q);
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BURST_C) begin
                        state_d = IDLE;
                        last_d  = sel_q;
                    end
                end else if (grant_rdy) begin
                    // Ready was offered but the requester had nothing: give up the grant.
                    state_d = IDLE;
                    last_d  = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = vld_q;
    assign o_data  = data_q;
    assign o_sel   = sel_q;
    assign o_busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux_col_rr_sched.sv
// Scenario tests plus a randomized run checked against a transaction-level model.
module tb_mux_col_rr_sched;

    localparam int COL   = 3;
    localparam int BURST = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [3:0]     i_valid;
    logic [COL-1:0] i_data1, i_data2, i_data3, i_data4;
    logic [3:0]     o_ready;
    logic           i_ready;
    logic           o_valid;
    logic [COL-1:0] o_data;
    logic [1:0]     o_sel;
    logic           o_busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the column, how many beats it has moved,
    // who was served last, and what sits in the output stage.
    bit             m_busy;
    int             m_sel;
    int             m_last;
    int             m_beats;
    bit             m_vld;
    logic [COL-1:0] m_data;

    mux_col_rr_sched #(.COL(COL), .BURST(BURST)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .i_data3 (i_data3),
        .i_data4 (i_data4),
        .o_ready (o_ready),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [COL-1:0] req_data(input int n);
        case (n)
            0:       return i_data1;
            1:       return i_data2;
            2:       return i_data3;
            default: return i_data4;
        endcase
    endfunction

    // Advance the model by one clock from the current inputs, then clock the DUT.
    task automatic clk_step();
        bit rdy, acc, found;
        rdy = m_busy && (!m_vld || i_ready);
        acc = rdy && i_valid[m_sel];
        if (i_rst) begin
            m_busy = 0; m_sel = 0; m_last = 3; m_beats = 0; m_vld = 0; m_data = '0;
        end else begin
            if (acc) begin
                m_data = req_data(m_sel);
                m_vld  = 1;
            end else if (m_vld && i_ready) begin
                m_vld = 0;
            end
            if (!m_busy) begin
                if (i_valid != 4'b0) begin
                    found = 0;
                    for (int j = 1; j <= 4; j++) begin
                        if (!found && i_valid[(m_last + j) % 4]) begin
                            m_sel = (m_last + j) % 4;
                            found = 1;
                        end
                    end
                    m_busy  = 1;
                    m_beats = 0;
                end
            end else if (acc) begin
                m_beats++;
                if (m_beats == BURST) begin
                    m_busy = 0;
                    m_last = m_sel;
                end
            end else if (rdy) begin
                m_busy = 0;
                m_last = m_sel;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 4'b0;
        clk_step();
        i_rst   = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 4'b0; i_ready = 1'b0;
        i_data1 = '0; i_data2 = '0; i_data3 = '0; i_data4 = '0;
        clk_step();
        clk_step();
        settle();
        n_total++;
        if ({o_valid, o_data, o_busy, o_sel, o_ready} !== {1'b0, 3'd0, 1'b0, 2'd0, 4'd0})
            $display("FAIL reset_outputs got v=%b d=%h busy=%b sel=%0d rdy=%b want all zero",
                     o_valid, o_data, o_busy, o_sel, o_ready);
        else n_pass++;
        i_rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        i_valid = 4'b0001; i_data1 = 3'h5; i_ready = 1'b1;
        settle();
        n_total++;
        if ({o_busy, o_ready} !== 5'b0)
            $display("FAIL single_idle got busy=%b rdy=%b want 0 0000", o_busy, o_ready);
        else n_pass++;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_sel, o_ready} !== {1'b1, 2'd0, 4'b0001})
            $display("FAIL single_grant got busy=%b sel=%0d rdy=%b want 1 0 0001", o_busy, o_sel, o_ready);
        else n_pass++;
        clk_step();
        i_valid = 4'b0000;
        settle();
        n_total++;
        if ({o_valid, o_data} !== {1'b1, 3'h5})
            $display("FAIL single_data got v=%b d=%h want 1 5", o_valid, o_data);
        else n_pass++;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_valid, o_data} !== {1'b0, 1'b0, 3'h5})
            $display("FAIL single_hold got busy=%b v=%b d=%h want 0 0 5", o_busy, o_valid, o_data);
        else n_pass++;
    endtask

    task automatic test_all_valid();
        logic [1:0] es;
        logic [3:0] er;
        logic [2:0] ed;
        do_reset();
        i_valid = 4'hf; i_ready = 1'b1;
        i_data1 = 3'd1; i_data2 = 3'd2; i_data3 = 3'd3; i_data4 = 3'd4;
        for (int b = 0; b < 5; b++) begin
            es = 2'(b % 4);
            er = 4'b0001 << es;
            ed = 3'(b % 4 + 1);
            settle();
            n_total++;
            if ({o_busy, o_ready} !== 5'b0)
                $display("FAIL rr_idle burst=%0d got busy=%b rdy=%b want 0 0000", b, o_busy, o_ready);
            else n_pass++;
            clk_step();
            for (int k = 0; k < BURST; k++) begin
                settle();
                n_total++;
                if ({o_busy, o_sel, o_ready} !== {1'b1, es, er})
                    $display("FAIL rr_grant burst=%0d beat=%0d got busy=%b sel=%0d rdy=%b want 1 %0d %b",
                             b, k, o_busy, o_sel, o_ready, es, er);
                else n_pass++;
                if (k > 0) begin
                    n_total++;
                    if ({o_valid, o_data} !== {1'b1, ed})
                        $display("FAIL rr_data burst=%0d beat=%0d got v=%b d=%h want 1 %h",
                                 b, k, o_valid, o_data, ed);
                    else n_pass++;
                end
                clk_step();
            end
        end
        i_valid = 4'b0;
        clk_step();
    endtask

    task automatic test_release_idle();
        do_reset();
        i_valid = 4'b0100; i_ready = 1'b1; i_data3 = 3'h6;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_sel} !== {1'b1, 2'd2})
            $display("FAIL rel_grant2 got busy=%b sel=%0d want 1 2", o_busy, o_sel);
        else n_pass++;
        clk_step();
        clk_step();
        i_valid = 4'b0000;
        settle();
        n_total++;
        if (o_ready !== 4'b0100)
            $display("FAIL rel_still_granted got rdy=%b want 0100", o_ready);
        else n_pass++;
        clk_step();
        settle();
        n_total++;
        if (o_busy !== 1'b0)
            $display("FAIL rel_idle got busy=%b want 0", o_busy);
        else n_pass++;
        i_valid = 4'b1010;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_sel} !== {1'b1, 2'd3})
            $display("FAIL rel_fair3 got busy=%b sel=%0d want 1 3", o_busy, o_sel);
        else n_pass++;
        i_valid = 4'b0;
        clk_step();
        clk_step();
    endtask

    task automatic test_stall();
        do_reset();
        i_valid = 4'b0001; i_ready = 1'b1;
        clk_step();
        i_data1 = 3'd1; clk_step();
        i_data1 = 3'd2; clk_step();
        i_ready = 1'b0; i_data1 = 3'd3;
        for (int s = 0; s < 3; s++) begin
            i_valid = (s == 1) ? 4'b0000 : 4'b0001;
            settle();
            n_total++;
            if ({o_ready, o_valid, o_data, o_busy} !== {4'b0000, 1'b1, 3'd2, 1'b1})
                $display("FAIL stall_hold cyc=%0d got rdy=%b v=%b d=%h busy=%b want 0000 1 2 1",
                         s, o_ready, o_valid, o_data, o_busy);
            else n_pass++;
            clk_step();
        end
        i_valid = 4'b0001; i_ready = 1'b1;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_valid, o_data} !== {1'b1, 1'b1, 3'd3})
            $display("FAIL stall_resume got busy=%b v=%b d=%h want 1 1 3", o_busy, o_valid, o_data);
        else n_pass++;
        i_data1 = 3'd4;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_valid, o_data} !== {1'b0, 1'b1, 3'd4})
            $display("FAIL stall_total4 got busy=%b v=%b d=%h want 0 1 4", o_busy, o_valid, o_data);
        else n_pass++;
        i_valid = 4'b0;
        clk_step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_valid = 4'b0110; i_ready = 1'b1; i_data2 = 3'h6;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_sel} !== {1'b1, 2'd1})
            $display("FAIL rm_grant1 got busy=%b sel=%0d want 1 1", o_busy, o_sel);
        else n_pass++;
        clk_step();
        i_rst = 1'b1;
        clk_step();
        settle();
        n_total++;
        if ({o_valid, o_busy, o_sel, o_ready} !== {1'b0, 1'b0, 2'd0, 4'b0})
            $display("FAIL rm_abort got v=%b busy=%b sel=%0d rdy=%b want 0 0 0 0000",
                     o_valid, o_busy, o_sel, o_ready);
        else n_pass++;
        i_rst = 1'b0; i_valid = 4'hf;
        clk_step();
        settle();
        n_total++;
        if ({o_busy, o_sel} !== {1'b1, 2'd0})
            $display("FAIL rm_prio0 got busy=%b sel=%0d want 1 0", o_busy, o_sel);
        else n_pass++;
        i_valid = 4'b0;
        clk_step();
        clk_step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] ed;
        do_reset();
        i_valid = 4'b0001; i_ready = 1'b1;
        clk_step();
        for (int k = 0; k < BURST; k++) begin
            ed = 3'(k + 3);
            i_data1 = ed;
            clk_step();
            settle();
            n_total++;
            if ({o_valid, o_data} !== {1'b1, ed})
                $display("FAIL b2b beat=%0d got v=%b d=%h want 1 %h", k, o_valid, o_data, ed);
            else n_pass++;
        end
        i_valid = 4'b0;
        clk_step();
    endtask

    task automatic test_random();
        logic [3:0]     e_rdy;
        logic [COL-1:0] e_data;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            i_rst = ($urandom_range(0, 63) == 0);
            for (int r = 0; r < 4; r++)
                if ($urandom_range(0, 3) == 0) i_valid[r] = ~i_valid[r];
            i_ready = ($urandom_range(0, 3) != 0);
            i_data1 = COL'($urandom); i_data2 = COL'($urandom);
            i_data3 = COL'($urandom); i_data4 = COL'($urandom);
            settle();
            e_rdy  = (m_busy && (!m_vld || i_ready)) ? (4'b0001 << m_sel) : 4'b0000;
            e_data = m_data;
            n_total++;
            if ({o_ready, o_valid, o_data, o_sel, o_busy} !== {e_rdy, m_vld, e_data, 2'(m_sel), m_busy})
                $display("FAIL random cyc=%0d got rdy=%b v=%b d=%h sel=%0d busy=%b want %b %b %h %0d %b",
                         c, o_ready, o_valid, o_data, o_sel, o_busy, e_rdy, m_vld, e_data, m_sel, m_busy);
            else n_pass++;
            clk_step();
        end
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_release_idle();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
